// File: rtl/bfm_ahb_cmd_master_if.sv
// Command/response and AHB-Lite signal bundle for the bench-side AHB initiator.
// The master modport is the initiator's view. The slave modport is the sequencer/bus side.
interface bfm_ahb_cmd_master_if #(
    parameter int AWIDTH = 32
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WRITE;
    logic [AWIDTH-1:0] CMD_ADDR;
    logic [2:0]        CMD_SIZE;
    logic [31:0]       CMD_WDATA;
    logic              RSP_VALID;
    logic [31:0]       RSP_RDATA;
    logic              RSP_ERROR;
    logic [AWIDTH-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic              HMASTLOCK;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
        input  HRDATA, HREADY, HRESP,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERROR,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
        output HRDATA, HREADY, HRESP,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERROR,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/bfm_ahb_cmd_master.sv
// Single-transfer AHB-Lite initiator: one command in, one SINGLE/NONSEQ transfer, one response pulse.
// Optional wait-state timeout is enabled by defining BFM_AHBMASTER_TIMEOUT_EN.
module bfm_ahb_cmd_master #(
    parameter int AWIDTH   = 32,
    parameter int TOCYCLES = 256
) (
    input logic                   HCLK,
    input logic                   HRESETN,
    bfm_ahb_cmd_master_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [AWIDTH-1:0] haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_error_q, rsp_error_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              misaligned;
    logic              timeout_hit;

    if (TOCYCLES < 2) begin : g_bad_tocycles
        $error("bfm_ahb_cmd_master: TOCYCLES must be >= 2");
    end

    assign misaligned = (bus.CMD_SIZE > 3'd2)
                     || (bus.CMD_SIZE == 3'd1 && bus.CMD_ADDR[0])
                     || (bus.CMD_SIZE == 3'd2 && bus.CMD_ADDR[1:0] != 2'b00);

`ifdef BFM_AHBMASTER_TIMEOUT_EN
    localparam int CW = $clog2(TOCYCLES) + 1;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          waiting;

    // Counts consecutive HREADY=0 cycles; any ready cycle or phase change restarts it.
    assign waiting     = (state_q == S_ADDR || state_q == S_DATA) && !bus.HREADY;
    assign timeout_hit = waiting && (to_cnt_q == CW'(TOCYCLES - 1));
    assign to_cnt_d    = (waiting && !timeout_hit) ? to_cnt_q + CW'(1) : '0;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                htrans_d    = 2'b00;
                if (bus.CMD_VALID && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (misaligned) begin
                        // Rejected locally: the bus never sees this command.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d  = S_ADDR;
                        htrans_d = 2'b10;
                        haddr_d  = bus.CMD_ADDR;
                        hwrite_d = bus.CMD_WRITE;
                        hsize_d  = bus.CMD_SIZE;
                        wdata_d  = bus.CMD_WDATA;
                    end
                end
            end
            S_ADDR: begin
                if (bus.HREADY) begin
                    state_d  = S_DATA;
                    htrans_d = 2'b00;
                    if (hwrite_q) hwdata_d = wdata_q;
                end else if (timeout_hit) begin
                    state_d     = S_RESP;
                    htrans_d    = 2'b00;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = 32'hDEAD_DEAD;
                end
            end
            S_DATA: begin
                // First cycle of a two-cycle ERROR has HREADY=0 and is treated as a wait.
                if (bus.HREADY) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = bus.HRESP;
                    rsp_rdata_d = (!hwrite_q && !bus.HRESP) ? bus.HRDATA : 32'h0;
                end else if (timeout_hit) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = 32'hDEAD_DEAD;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= 2'b00;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.CMD_READY = cmd_ready_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_RDATA = rsp_rdata_q;
    assign bus.RSP_ERROR = rsp_error_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;
endmodule
